// File: rtl/kcm_block_accumulator_pkg.sv
// Shared definitions for the KCM product path and the block accumulator.
// Holds the product width used by the multiplier and the output state encoding.
// Also provides the derived accumulator width helper.
package kcm_pkg;

    localparam int KCM_DATA_W = 10;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    // Width needed to hold an exact sum of block_len products.
    function automatic int acc_width(input int block_len);
        return KCM_DATA_W + $clog2(block_len);
    endfunction

endpackage

// File: rtl/kcm_block_accumulator_if.sv
// Stream bundle between the KCM multiplier, the block accumulator and its consumer.
// Input side carries products plus a clear strobe; output side carries block results.
// master drives products and out_ready; slave is the accumulator.
interface kcm_block_accumulator_if
    #(
        parameter int DATA_W = kcm_pkg::KCM_DATA_W,
        parameter int ACC_W  = kcm_pkg::KCM_DATA_W + 4
    );

    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum
    );

endinterface

// File: rtl/kcm_block_accumulator_round.sv
// Rounding divider: block sum -> block mean, round half up, zero-extended.
// Latency: purely combinational.
// Backpressure: none; used only when KCM_ACC_MEAN_EN is defined.
module kcm_acc_round
    #(
        parameter int DATA_W = 10,
        parameter int CNT_W  = 4,
        parameter int ACC_W  = DATA_W + CNT_W
    )
    (
        input  logic [ACC_W-1:0] sum_i,
        output logic [ACC_W-1:0] mean_o
    );

    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (CNT_W - 1);

    // The biased sum cannot overflow ACC_W: the largest sum is
    // 2^ACC_W - 2^CNT_W, so adding 2^(CNT_W-1) stays in range.
    logic [ACC_W-1:0] biased;

    // Add half an LSB of the quotient, then drop the fraction bits.
    always_comb begin
        biased = sum_i + HALF;
        mean_o = biased >> CNT_W;
    end

endmodule

// File: rtl/kcm_block_accumulator.sv
// Sums blocks of BLOCK_LEN KCM products; block mean instead if KCM_ACC_MEAN_EN is defined.
// Latency: result valid the cycle after the block-completing product is accepted.
// Backpressure: one-entry output register; only the block-completing product waits on a stalled output.
module kcm_block_accumulator
    import kcm_pkg::*;
    #(
        parameter int BLOCK_LEN = 16
    )
    (
        input  logic                   clk,
        input  logic                   rst_n,
        kcm_block_accumulator_if.slave bus
    );

    localparam int DATA_W = KCM_DATA_W;
    localparam int CNT_W  = $clog2(BLOCK_LEN);
    localparam int ACC_W  = DATA_W + CNT_W;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    out_state_e       state_q, state_d;

    logic             last_slot;
    logic             in_rdy;
    logic             accept;
    logic             final_acc;
    logic [ACC_W-1:0] blk_sum;
    logic [ACC_W-1:0] blk_result;

    // Handshake decode. Only the block-completing product is held off while
    // the output register is full and not being drained this cycle.
    always_comb begin
        last_slot = (cnt_q == CNT_LAST);
        in_rdy    = ~bus.clear & ~(last_slot & (state_q == FULL) & ~bus.out_ready);
        accept    = bus.in_valid & in_rdy;
        final_acc = accept & last_slot;
        blk_sum   = acc_q + ACC_W'(bus.in_data);
    end

`ifdef KCM_ACC_MEAN_EN
    kcm_acc_round #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .ACC_W  (ACC_W)
    ) u_round (
        .sum_i  (blk_sum),
        .mean_o (blk_result)
    );
`else
    assign blk_result = blk_sum;
`endif

    // Running partial sum and sample count; clear discards the partial block.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (bus.clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (last_slot) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = blk_sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Output register FSM: a final sample always loads, even while draining,
    // so back-to-back blocks leave no bubble.
    always_comb begin
        state_d   = state_q;
        out_sum_d = out_sum_q;
        case (state_q)
            EMPTY: begin
                if (final_acc) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (final_acc) begin
                    state_d = FULL;
                end else if (bus.out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (final_acc) begin
            out_sum_d = blk_result;
        end
    end

    // State registers; reset drops any partial block and any held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            out_sum_q <= '0;
            state_q   <= EMPTY;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_sum_q <= out_sum_d;
            state_q   <= state_d;
        end
    end

    // Drive the interface outputs from the registered state.
    always_comb begin
        bus.in_ready  = in_rdy;
        bus.out_valid = (state_q == FULL);
        bus.out_sum   = out_sum_q;
    end

endmodule

// File: tb/tb_kcm_block_accumulator.sv
// Testbench for kcm_block_accumulator with BLOCK_LEN = 4.
// Directed scenarios followed by randomized traffic against a block-level model.
// Honours KCM_ACC_MEAN_EN for the expected results.
module tb_kcm_block_accumulator;

    localparam int L      = 4;
    localparam int DATA_W = 10;
    localparam int ACC_W  = DATA_W + $clog2(L);

    logic clk;
    logic rst_n;

    kcm_block_accumulator_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    kcm_block_accumulator #(.BLOCK_LEN(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: products of the current block, and the held result.
    int blk[$];
    bit m_full;
    int m_val;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int block_result(input int s);
`ifdef KCM_ACC_MEAN_EN
        return (s + L / 2) / L;
`else
        return s;
`endif
    endfunction

    // One clock cycle: apply inputs just after a rising edge, check outputs
    // mid-cycle against the model, then advance the model and the clock.
    task automatic step(input bit v, input int d, input bit ordy, input bit clr);
        bit exp_rdy;
        int s;
        bus.in_valid  = v;
        bus.in_data   = DATA_W'(d);
        bus.out_ready = ordy;
        bus.clear     = clr;
        #3;
        exp_rdy = !clr && !((blk.size() == L - 1) && m_full && !ordy);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(m_full));
        if (m_full) chk("out_sum", 32'(bus.out_sum), 32'(m_val));
        if (m_full && ordy) m_full = 1'b0;
        if (clr) begin
            blk.delete();
        end else if (v && exp_rdy) begin
            blk.push_back(d);
            if (blk.size() == L) begin
                s = 0;
                foreach (blk[i]) s += blk[i];
                blk.delete();
                m_full = 1'b1;
                m_val  = block_result(s);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from the clock edge.
    task automatic pulse_reset();
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        blk.delete();
        m_full = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int a, input int b, input int c, input int d, input bit ordy);
        step(1, a, ordy, 0);
        step(1, b, ordy, 0);
        step(1, c, ordy, 0);
        step(1, d, ordy, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        m_full        = 1'b0;
        m_val         = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_sum", 32'(bus.out_sum), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

        // 1,2,3,4 streamed with the consumer always ready.
        feed(1, 2, 3, 4, 1);
`ifdef KCM_ACC_MEAN_EN
        chk("blk_1234", 32'(bus.out_sum), 32'd3);
`else
        chk("blk_1234", 32'(bus.out_sum), 32'd10);
`endif
        chk("blk_1234_vld", 32'(bus.out_valid), 32'd1);

        // Largest products: exact sum must not overflow.
        feed(1023, 1023, 1023, 1023, 1);
`ifdef KCM_ACC_MEAN_EN
        chk("blk_max", 32'(bus.out_sum), 32'd1023);
`else
        chk("blk_max", 32'(bus.out_sum), 32'd4092);
`endif

        // Mean rounding edge patterns (exact sums in the default build).
        feed(0, 0, 0, 1, 1);
        feed(0, 0, 1, 1, 1);
        step(0, 0, 1, 0);

        // Stalled output: 1..4 completes, 5..7 still accepted, 8 must wait.
        feed(1, 2, 3, 4, 0);
        step(1, 5, 0, 0);
        step(1, 6, 0, 0);
        step(1, 7, 0, 0);
        step(1, 8, 0, 0);
        step(1, 8, 0, 0);
        step(1, 8, 1, 0);
`ifdef KCM_ACC_MEAN_EN
        chk("stall_second", 32'(bus.out_sum), 32'd7);
`else
        chk("stall_second", 32'(bus.out_sum), 32'd26);
`endif
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // Clear discards a partial block and refuses the concurrent sample.
        step(1, 5, 1, 0);
        step(1, 5, 1, 0);
        step(1, 9, 1, 1);
        feed(1, 2, 3, 4, 1);
`ifdef KCM_ACC_MEAN_EN
        chk("after_clear", 32'(bus.out_sum), 32'd3);
`else
        chk("after_clear", 32'(bus.out_sum), 32'd10);
`endif
        step(0, 0, 1, 0);

        // Reset mid-block, then while a result is held.
        step(1, 100, 1, 0);
        step(1, 200, 1, 0);
        pulse_reset();
        feed(7, 8, 9, 10, 0);
        step(0, 0, 0, 0);
        pulse_reset();
        feed(11, 12, 13, 14, 1);
        step(0, 0, 1, 0);

        // Randomized traffic: bursty valid, stalls, rare clears, max values.
        for (int i = 0; i < 3000; i++) begin
            int d;
            d = ($urandom_range(0, 9) == 0) ? 1023 : int'($urandom_range(0, 1023));
            step($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 49) == 0);
        end
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/kcm_block_accumulator.md
# kcm_block_accumulator

Streaming stage directly downstream of the constant-coefficient (KCM) multiplier: it consumes the multiplier's 10-bit unsigned products one per cycle over a valid/ready handshake. It sums fixed-length blocks of BLOCK_LEN products and emits one block sum per block through a single-entry output register with valid/ready backpressure. It is the first clocked stage after the purely combinational KCM path.

## Interface
- DATA_W, 10, width of incoming unsigned product (KCM output width)
- BLOCK_LEN, 16, products per block; power of two, ≥ 2
- ACC_W, DATA_W + $clog2(BLOCK_LEN), accumulator and output width (derived, not overridden)

- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  reset, asynchronous assert, active-low
- clear  input  1  synchronous discard of the partial block
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept in_data this cycle
- in_data  input  DATA_W  unsigned product from KCM
- out_valid  output  1  out_sum holds a completed block result
- out_ready  input  1  downstream accepts out_sum
- out_sum  output  ACC_W  block result (sum, or mean with macro)

## Operation
- Accept = in_valid & in_ready. On accept: acc += in_data, cnt += 1 (cnt width $clog2(BLOCK_LEN), wraps BLOCK_LEN-1 → 0).
- Final sample = accept while cnt == BLOCK_LEN-1: out register loads acc + in_data, acc ← 0, cnt ← 0, out_valid ← 1.
- Sum is exact: max BLOCK_LEN·(2^DATA_W−1) fits ACC_W; no overflow logic.
- Output state machine, two states:
  - EMPTY: out_valid=0. Final sample → FULL.
  - FULL: out_valid=1, out_sum stable. out_ready=1 with no final sample → EMPTY. out_ready=1 with a simultaneous final sample → stay FULL, new result loaded (no bubble).
- in_ready = ~clear & ~(cnt == BLOCK_LEN-1 & state==FULL & ~out_ready). Non-final samples are always accepted while the output is stalled; only the block-completing sample is held off.
- clear: acc ← 0, cnt ← 0, in_ready forced 0 that cycle (concurrent in_valid not accepted, upstream holds). Output register and state unaffected.
- Reset mid-block or mid-hold: all state lost; no partial result emitted.

## Timing
- Reset values: in_ready=1 (after release, clear low), out_valid=0, out_sum=0, acc=0, cnt=0, state EMPTY.
- Latency: out_valid rises the cycle after the final sample is accepted.
- Throughput: one product per cycle sustained when out_ready held high; one result per BLOCK_LEN cycles.
- out_sum and out_valid are registered; in_ready is combinational from cnt, state, out_ready, clear.
- Once out_valid=1, out_sum does not change until the handshake completes.

## Configuration
- KCM_ACC_MEAN_EN defined: out_sum = (sum + BLOCK_LEN/2) >> $clog2(BLOCK_LEN), round half up, zero-extended to ACC_W (upper bits always 0; result ≤ 2^DATA_W−1).
- Undefined: out_sum = exact block sum. Handshake and timing identical in both builds.

## Structure
- Shared package kcm_pkg: KCM_DATA_W = 10 constant (shared with the multiplier), output state enum {EMPTY, FULL}.
- One sub-module is natural: kcm_acc_round, combinational rounding divider, instantiated only under KCM_ACC_MEAN_EN.

## Test plan
- BLOCK_LEN=4, out_ready=1, samples 1,2,3,4 back-to-back → out_valid one cycle after "4" accepted, out_sum=10; in_ready never drops.
- BLOCK_LEN=16, 16 × 1023 → out_sum=16368 (0x3FF0); with KCM_ACC_MEAN_EN → 1023.
- BLOCK_LEN=4, out_ready=0, feed 1..8 → first result 10 held; samples 5,6,7 accepted, in_ready=0 at cnt=3 while 8 waits; raise out_ready → 10 drained, 8 accepted same cycle, next cycle out_sum=26.
- Samples 5,5 then clear with in_valid=1, data 9 → 9 not accepted that cycle; then 1,2,3,4 → out_sum=10 (pre-clear data discarded).
- KCM_ACC_MEAN_EN, BLOCK_LEN=4, samples 1,2,3,4 → out_sum=3; samples 0,0,0,1 → 0; samples 0,0,1,1 → 1.
- rst_n pulsed low mid-block (after 2 samples) and again while FULL → out_valid=0 immediately (asynchronous), next full block from zero gives correct sum.
